// File: rtl/wb_pkg.sv
// Shared widths, bus field offsets and width helpers for the write-back stage.
package wb_pkg;

   localparam int unsigned XLEN_DEF        = 32;
   localparam int unsigned NREG_W_DEF      = 5;
   localparam int unsigned TRACE_DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF       = 32;

   // MEM->WB bus: {wstrb, dest, result, pc}
   function automatic int unsigned ms_to_ws_w(input int unsigned xlen,
                                              input int unsigned nreg_w,
                                              input int unsigned wstrb_w);
      return wstrb_w + nreg_w + 2 * xlen;
   endfunction

   // WB->RF bus: {ws_valid, rf_wstrb, rf_waddr, rf_wdata}
   function automatic int unsigned ws_to_rf_w(input int unsigned xlen,
                                              input int unsigned nreg_w,
                                              input int unsigned wstrb_w);
      return 1 + wstrb_w + nreg_w + xlen;
   endfunction

   // Trace record: {pc, wen, wnum, wdata}
   function automatic int unsigned trace_rec_w(input int unsigned xlen,
                                               input int unsigned nreg_w,
                                               input int unsigned wstrb_w);
      return xlen + wstrb_w + nreg_w + xlen;
   endfunction

   function automatic int unsigned ms_pc_lsb();
      return 0;
   endfunction

   function automatic int unsigned ms_result_lsb(input int unsigned xlen);
      return xlen;
   endfunction

   function automatic int unsigned ms_dest_lsb(input int unsigned xlen);
      return 2 * xlen;
   endfunction

   function automatic int unsigned ms_wstrb_lsb(input int unsigned xlen,
                                                input int unsigned nreg_w);
      return 2 * xlen + nreg_w;
   endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular-buffer FIFO holding retire records; pointers carry one wrap bit
// so full and empty come straight from the pointer pair.
module wb_trace_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_empty   = (r_wptr == r_rptr);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Head is forced to zero while empty so stale entries never leak out.
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/wb_stage_trace.sv
// Pipeline write-back stage: drives the RF write/bypass bus, counts retires and
// queues one trace record per retired instruction for a back-pressuring consumer.
module wb_stage_trace
   import wb_pkg::*;
#(
   parameter int unsigned XLEN        = XLEN_DEF,
   parameter int unsigned NREG_W      = NREG_W_DEF,
   parameter int unsigned WSTRB_W     = XLEN / 8,
   parameter int unsigned TRACE_DEPTH = TRACE_DEPTH_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                                          clk,
   input  logic                                          resetn,
   output logic                                          ws_allowin,
   input  logic                                          ms_to_ws_valid,
   input  logic [ms_to_ws_w(XLEN, NREG_W, WSTRB_W)-1:0]  ms_to_ws_bus,
   input  logic                                          ws_flush,
   output logic [ws_to_rf_w(XLEN, NREG_W, WSTRB_W)-1:0]  ws_to_rf_bus,
   output logic [CNT_W-1:0]                              retire_cnt,
   output logic                                          debug_valid,
   input  logic                                          debug_ready,
   output logic [XLEN-1:0]                               debug_wb_pc,
   output logic [WSTRB_W-1:0]                            debug_wb_rf_wen,
   output logic [NREG_W-1:0]                             debug_wb_rf_wnum,
   output logic [XLEN-1:0]                               debug_wb_rf_wdata
);

   localparam int unsigned BUS_W      = ms_to_ws_w(XLEN, NREG_W, WSTRB_W);
   localparam int unsigned REC_W      = trace_rec_w(XLEN, NREG_W, WSTRB_W);
   localparam int unsigned PC_LSB     = ms_pc_lsb();
   localparam int unsigned RESULT_LSB = ms_result_lsb(XLEN);
   localparam int unsigned DEST_LSB   = ms_dest_lsb(XLEN);
   localparam int unsigned WSTRB_LSB  = ms_wstrb_lsb(XLEN, NREG_W);
   localparam int unsigned REC_WNUM   = XLEN;
   localparam int unsigned REC_WEN    = XLEN + NREG_W;
   localparam int unsigned REC_PC     = XLEN + NREG_W + WSTRB_W;

   logic               r_ws_valid;
   logic [BUS_W-1:0]   r_ws_bus;
   logic [CNT_W-1:0]   r_retire_cnt;

   logic [XLEN-1:0]    w_pc;
   logic [XLEN-1:0]    w_result;
   logic [NREG_W-1:0]  w_dest;
   logic [WSTRB_W-1:0] w_wstrb;
   logic [WSTRB_W-1:0] w_rf_wstrb;
   logic               w_ready_go;
   logic               w_retire;
   logic               w_load;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_pop;
   logic [REC_W-1:0]   w_push_rec;
   logic [REC_W-1:0]   w_head_rec;

   assign w_pc     = r_ws_bus[PC_LSB     +: XLEN];
   assign w_result = r_ws_bus[RESULT_LSB +: XLEN];
   assign w_dest   = r_ws_bus[DEST_LSB   +: NREG_W];
   assign w_wstrb  = r_ws_bus[WSTRB_LSB  +: WSTRB_W];

   // Stall only on a full trace FIFO; a same-cycle pop does not free a slot.
   assign w_ready_go = !w_fifo_full;
   assign ws_allowin = !r_ws_valid || w_ready_go;
   assign w_retire   = r_ws_valid && w_ready_go && !ws_flush;
   assign w_load     = ms_to_ws_valid && ws_allowin && !ws_flush;

   assign w_rf_wstrb   = (w_retire && (w_dest != '0)) ? w_wstrb : '0;
   assign ws_to_rf_bus = {r_ws_valid, w_rf_wstrb, w_dest, w_result};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ws_valid <= 1'b0;
      end else if (ws_flush) begin
         r_ws_valid <= 1'b0;
      end else if (ws_allowin) begin
         r_ws_valid <= ms_to_ws_valid;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ws_bus <= '0;
      end else if (w_load) begin
         r_ws_bus <= ms_to_ws_bus;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_retire_cnt <= '0;
      end else if (w_retire) begin
         r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
   end

   assign retire_cnt = r_retire_cnt;

   assign w_push_rec = {w_pc, w_rf_wstrb, w_dest, w_result};
   assign w_pop      = !w_fifo_empty && debug_ready;

   wb_trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (REC_W)
   ) u_trace_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_retire),
      .i_wdata (w_push_rec),
      .i_pop   (w_pop),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_rdata (w_head_rec)
   );

   assign debug_valid       = !w_fifo_empty;
   assign debug_wb_pc       = w_head_rec[REC_PC   +: XLEN];
   assign debug_wb_rf_wen   = w_head_rec[REC_WEN  +: WSTRB_W];
   assign debug_wb_rf_wnum  = w_head_rec[REC_WNUM +: NREG_W];
   assign debug_wb_rf_wdata = w_head_rec[0        +: XLEN];

endmodule

// File: tb/tb_wb_stage_trace.sv
// Directed bench for wb_stage_trace: RF bus, trace FIFO, back-pressure, flush,
// asynchronous reset and counter wrap (second instance with a 4-bit counter).
`timescale 1ns/1ps
module tb_wb_stage_trace;
   import wb_pkg::*;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NREG_W  = 5;
   localparam int unsigned WSTRB_W = 4;
   localparam int unsigned BUS_W   = ms_to_ws_w(XLEN, NREG_W, WSTRB_W);
   localparam int unsigned RF_W    = ws_to_rf_w(XLEN, NREG_W, WSTRB_W);

   logic               clk = 1'b0;
   logic               resetn;
   logic               ms_to_ws_valid;
   logic [BUS_W-1:0]   ms_to_ws_bus;
   logic               ws_flush;
   logic               debug_ready;

   logic               ws_allowin;
   logic [RF_W-1:0]    ws_to_rf_bus;
   logic [31:0]        retire_cnt;
   logic               debug_valid;
   logic [XLEN-1:0]    debug_wb_pc;
   logic [WSTRB_W-1:0] debug_wb_rf_wen;
   logic [NREG_W-1:0]  debug_wb_rf_wnum;
   logic [XLEN-1:0]    debug_wb_rf_wdata;

   logic               b_allowin;
   logic [RF_W-1:0]    b_rf_bus;
   logic [3:0]         b_retire_cnt;
   logic               b_debug_valid;
   logic [XLEN-1:0]    b_pc;
   logic [WSTRB_W-1:0] b_wen;
   logic [NREG_W-1:0]  b_wnum;
   logic [XLEN-1:0]    b_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_stage_trace u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_flush          (ws_flush),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .retire_cnt        (retire_cnt),
      .debug_valid       (debug_valid),
      .debug_ready       (debug_ready),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   wb_stage_trace #(.CNT_W(4)) u_dut_cnt4 (
      .clk               (clk),
      .resetn            (resetn),
      .ws_allowin        (b_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_flush          (ws_flush),
      .ws_to_rf_bus      (b_rf_bus),
      .retire_cnt        (b_retire_cnt),
      .debug_valid       (b_debug_valid),
      .debug_ready       (debug_ready),
      .debug_wb_pc       (b_pc),
      .debug_wb_rf_wen   (b_wen),
      .debug_wb_rf_wnum  (b_wnum),
      .debug_wb_rf_wdata (b_wdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] s, input logic [4:0] d,
                        input logic [31:0] r, input logic [31:0] p);
      ms_to_ws_valid = 1'b1;
      ms_to_ws_bus   = {s, d, r, p};
   endtask

   // Inputs change and outputs are sampled 1 ns after the falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      resetn         = 1'b0;
      ms_to_ws_valid = 1'b0;
      ms_to_ws_bus   = '0;
      ws_flush       = 1'b0;
      debug_ready    = 1'b1;
      #2;
      check("rst_allowin", 64'(ws_allowin), 64'd1);
      check("rst_dvalid",  64'(debug_valid), 64'd0);
      check("rst_cnt",     64'(retire_cnt), 64'd0);
      check("rst_rfbus",   64'(ws_to_rf_bus), 64'd0);
      tick();
      resetn = 1'b1;
      tick();

      // Single retire
      drive(4'hF, 5'd5, 32'h12345678, 32'hBFC00000);
      tick();
      ms_to_ws_valid = 1'b0;
      check("single_rfbus",  64'(ws_to_rf_bus), 64'({1'b1, 4'hF, 5'd5, 32'h12345678}));
      check("single_dv_early", 64'(debug_valid), 64'd0);
      check("single_cnt_early", 64'(retire_cnt), 64'd0);
      tick();
      check("single_dvalid", 64'(debug_valid), 64'd1);
      check("single_pc",     64'(debug_wb_pc), 64'hBFC00000);
      check("single_wen",    64'(debug_wb_rf_wen), 64'hF);
      check("single_wnum",   64'(debug_wb_rf_wnum), 64'd5);
      check("single_wdata",  64'(debug_wb_rf_wdata), 64'h12345678);
      check("single_cnt",    64'(retire_cnt), 64'd1);
      check("single_rf_idle", 64'(ws_to_rf_bus), 64'({1'b0, 4'h0, 5'd5, 32'h12345678}));
      tick();
      check("single_drained", 64'(debug_valid), 64'd0);
      check("empty_pc_zero",  64'(debug_wb_pc), 64'd0);

      // Dest zero: traced but no RF write
      drive(4'hF, 5'd0, 32'hCAFEF00D, 32'h00000100);
      tick();
      ms_to_ws_valid = 1'b0;
      check("dz_rfbus", 64'(ws_to_rf_bus), 64'({1'b1, 4'h0, 5'd0, 32'hCAFEF00D}));
      tick();
      check("dz_dvalid", 64'(debug_valid), 64'd1);
      check("dz_pc",     64'(debug_wb_pc), 64'h100);
      check("dz_wen",    64'(debug_wb_rf_wen), 64'h0);
      check("dz_cnt",    64'(retire_cnt), 64'd2);

      // Partial strobe
      drive(4'b0011, 5'd7, 32'h000055AA, 32'h00000104);
      tick();
      ms_to_ws_valid = 1'b0;
      check("ps_rfbus", 64'(ws_to_rf_bus), 64'({1'b1, 4'b0011, 5'd7, 32'h000055AA}));
      tick();
      check("ps_wen",  64'(debug_wb_rf_wen), 64'h3);
      check("ps_wnum", 64'(debug_wb_rf_wnum), 64'd7);
      check("ps_cnt",  64'(retire_cnt), 64'd3);
      tick();
      check("ps_drained", 64'(debug_valid), 64'd0);

      // Back-pressure: five instructions into a 4-deep FIFO with no consumer
      debug_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(4'hF, 5'(i + 1), 32'hD0 + 32'(i), 32'h1000 + 32'(4 * i));
         tick();
      end
      ms_to_ws_valid = 1'b0;
      check("bp_allowin", 64'(ws_allowin), 64'd0);
      check("bp_rfbus",   64'(ws_to_rf_bus), 64'({1'b1, 4'h0, 5'd5, 32'hD4}));
      check("bp_cnt",     64'(retire_cnt), 64'd7);
      check("bp_head",    64'(debug_wb_pc), 64'h1000);
      tick();
      check("bp_hold_allowin", 64'(ws_allowin), 64'd0);
      check("bp_hold_cnt",     64'(retire_cnt), 64'd7);
      debug_ready = 1'b1;
      #1;
      check("bp_pop_no_push", 64'(ws_to_rf_bus), 64'({1'b1, 4'h0, 5'd5, 32'hD4}));
      tick();
      check("bp_pop1_pc",    64'(debug_wb_pc), 64'h1004);
      check("bp_retire_now", 64'(ws_to_rf_bus), 64'({1'b1, 4'hF, 5'd5, 32'hD4}));
      check("bp_pop1_cnt",   64'(retire_cnt), 64'd7);
      tick();
      check("bp_pop2_pc",  64'(debug_wb_pc), 64'h1008);
      check("bp_pop2_cnt", 64'(retire_cnt), 64'd8);
      check("bp_ws_empty", 64'(ws_to_rf_bus[RF_W-1]), 64'd0);
      check("bp_allowin2", 64'(ws_allowin), 64'd1);
      tick();
      check("bp_pop3_pc", 64'(debug_wb_pc), 64'h100C);
      tick();
      check("bp_pop4_pc",   64'(debug_wb_pc), 64'h1010);
      check("bp_pop4_wnum", 64'(debug_wb_rf_wnum), 64'd5);
      tick();
      check("bp_drained", 64'(debug_valid), 64'd0);

      // Flush with a valid instruction in WB and another one arriving
      drive(4'hF, 5'd9, 32'h99, 32'h2000);
      tick();
      drive(4'hF, 5'd10, 32'hAA, 32'h2004);
      ws_flush = 1'b1;
      #1;
      check("fl_no_write", 64'(ws_to_rf_bus), 64'({1'b1, 4'h0, 5'd9, 32'h99}));
      tick();
      ws_flush       = 1'b0;
      ms_to_ws_valid = 1'b0;
      check("fl_cleared", 64'(ws_to_rf_bus), 64'({1'b0, 4'h0, 5'd9, 32'h99}));
      check("fl_cnt",     64'(retire_cnt), 64'd8);
      check("fl_no_push", 64'(debug_valid), 64'd0);
      tick();
      check("fl_cnt2", 64'(retire_cnt), 64'd8);

      // Asynchronous reset in the middle of a stalled burst
      debug_ready = 1'b0;
      drive(4'hF, 5'd1, 32'h1, 32'h3000);
      tick();
      drive(4'hF, 5'd2, 32'h2, 32'h3004);
      tick();
      drive(4'hF, 5'd3, 32'h3, 32'h3008);
      #2;
      resetn = 1'b0;
      #1;
      check("ar_allowin", 64'(ws_allowin), 64'd1);
      check("ar_dvalid",  64'(debug_valid), 64'd0);
      check("ar_cnt",     64'(retire_cnt), 64'd0);
      check("ar_pc",      64'(debug_wb_pc), 64'd0);
      check("ar_wen",     64'(debug_wb_rf_wen), 64'd0);
      check("ar_wnum",    64'(debug_wb_rf_wnum), 64'd0);
      check("ar_wdata",   64'(debug_wb_rf_wdata), 64'd0);
      check("ar_rfbus",   64'(ws_to_rf_bus), 64'd0);
      ms_to_ws_valid = 1'b0;
      tick();
      resetn      = 1'b1;
      debug_ready = 1'b1;
      tick();

      // Counter wrap: 17 back-to-back retires
      for (int i = 0; i < 17; i++) begin
         drive(4'hF, 5'd1, 32'(i), 32'h4000 + 32'(4 * i));
         tick();
      end
      ms_to_ws_valid = 1'b0;
      tick();
      tick();
      check("wrap_cnt32", 64'(retire_cnt), 64'd17);
      check("wrap_cnt4",  64'(b_retire_cnt), 64'd1);
      check("wrap_drained", 64'(debug_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
